// File: rtl/wb_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : wb_arbiter_if
// Description : Writeback arbiter bus: two lane results, long-latency
//               handshake, and the two register-file write ports.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface wb_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic               eu0_wb_en;
    logic [4:0]         eu0_wb_rd;
    logic [31:0]        eu0_wb_data;
    logic               eu1_wb_en;
    logic [4:0]         eu1_wb_rd;
    logic [31:0]        eu1_wb_data;
    logic               lu_valid;
    logic               lu_ready;
    logic [4:0]         lu_rd;
    logic [31:0]        lu_data;
    logic               write_en_0;
    logic [4:0]         write_addr_0;
    logic [31:0]        write_data_0;
    logic               write_en_1;
    logic [4:0]         write_addr_1;
    logic [31:0]        write_data_1;
    logic [c_CNT_W-1:0] fifo_count;

    modport master (
        output eu0_wb_en, eu0_wb_rd, eu0_wb_data,
        output eu1_wb_en, eu1_wb_rd, eu1_wb_data,
        output lu_valid, lu_rd, lu_data,
        input  lu_ready,
        input  write_en_0, write_addr_0, write_data_0,
        input  write_en_1, write_addr_1, write_data_1,
        input  fifo_count
    );

    modport slave (
        input  eu0_wb_en, eu0_wb_rd, eu0_wb_data,
        input  eu1_wb_en, eu1_wb_rd, eu1_wb_data,
        input  lu_valid, lu_rd, lu_data,
        output lu_ready,
        output write_en_0, write_addr_0, write_data_0,
        output write_en_1, write_addr_1, write_data_1,
        output fifo_count
    );
endinterface

`default_nettype wire

// File: rtl/wb_arbiter.sv
//------------------------------------------------------------------------------
// Module      : wb_arbiter
// Description : Register-file writeback arbiter for two non-stalling lanes plus
//               a FIFO-buffered long-latency source draining into idle ports.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    wb_arbiter_if.slave  bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = 37;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic               r_wr_en_0;
    logic [4:0]         r_wr_addr_0;
    logic [31:0]        r_wr_data_0;
    logic               r_wr_en_1;
    logic [4:0]         r_wr_addr_1;
    logic [31:0]        r_wr_data_1;

    logic               w_e0;
    logic               w_e1;
    logic               w_ready;
    logic               w_push;
    logic               w_pop0;
    logic               w_pop1;
    logic [c_PTR_W-1:0] w_idx1;
    logic [c_ENT_W-1:0] w_ent0;
    logic [c_ENT_W-1:0] w_ent1;
    logic               w_wr0;
    logic               w_wr1;
    logic [4:0]         w_addr0;
    logic [4:0]         w_addr1;
    logic [31:0]        w_data0;
    logic [31:0]        w_data1;

    // Lane 1 is younger, so it wins a same-register conflict.
    assign w_e1 = bus.eu1_wb_en && (bus.eu1_wb_rd != 5'd0);
    assign w_e0 = bus.eu0_wb_en && (bus.eu0_wb_rd != 5'd0) &&
                  !(w_e1 && (bus.eu0_wb_rd == bus.eu1_wb_rd));

    // Registered occupancy only: a same-cycle pop never frees a slot for a push.
    assign w_ready = !rst && (r_count < c_FULL);
    assign w_push  = bus.lu_valid && w_ready;

    assign w_pop0 = !w_e0 && (r_count != '0);
    assign w_pop1 = !w_e1 && (w_pop0 ? (r_count >= c_CNT_W'(2)) : (r_count != '0));
    assign w_idx1 = w_pop0 ? (r_head + c_PTR_W'(1)) : r_head;
    assign w_ent0 = r_mem[r_head];
    assign w_ent1 = r_mem[w_idx1];

    assign w_wr0   = w_e0 || (w_pop0 && (w_ent0[36:32] != 5'd0));
    assign w_addr0 = w_e0 ? bus.eu0_wb_rd   : w_ent0[36:32];
    assign w_data0 = w_e0 ? bus.eu0_wb_data : w_ent0[31:0];
    assign w_wr1   = w_e1 || (w_pop1 && (w_ent1[36:32] != 5'd0));
    assign w_addr1 = w_e1 ? bus.eu1_wb_rd   : w_ent1[36:32];
    assign w_data1 = w_e1 ? bus.eu1_wb_data : w_ent1[31:0];

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= {bus.lu_rd, bus.lu_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + c_PTR_W'(w_push);
            r_head  <= r_head + c_PTR_W'(w_pop0) + c_PTR_W'(w_pop1);
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop0) - c_CNT_W'(w_pop1);
        end
    end

    // Address/data hold their last value on cycles where the port is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en_0   <= 1'b0;
            r_wr_addr_0 <= '0;
            r_wr_data_0 <= '0;
            r_wr_en_1   <= 1'b0;
            r_wr_addr_1 <= '0;
            r_wr_data_1 <= '0;
        end else begin
            r_wr_en_0 <= w_wr0;
            r_wr_en_1 <= w_wr1;
            if (w_wr0) begin
                r_wr_addr_0 <= w_addr0;
                r_wr_data_0 <= w_data0;
            end
            if (w_wr1) begin
                r_wr_addr_1 <= w_addr1;
                r_wr_data_1 <= w_data1;
            end
        end
    end

    assign bus.lu_ready     = w_ready;
    assign bus.write_en_0   = r_wr_en_0;
    assign bus.write_addr_0 = r_wr_addr_0;
    assign bus.write_data_0 = r_wr_data_0;
    assign bus.write_en_1   = r_wr_en_1;
    assign bus.write_addr_1 = r_wr_addr_1;
    assign bus.write_data_1 = r_wr_data_1;
    assign bus.fifo_count   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_wb_arbiter
// Description : Directed self-checking bench for wb_arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_arbiter;
    localparam int c_DEPTH = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    wb_arbiter_if #(.DEPTH(c_DEPTH)) bus ();

    wb_arbiter #(.DEPTH(c_DEPTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lanes(input logic en0, input logic [4:0] rd0, input logic [31:0] d0,
                         input logic en1, input logic [4:0] rd1, input logic [31:0] d1);
        bus.eu0_wb_en   = en0;
        bus.eu0_wb_rd   = rd0;
        bus.eu0_wb_data = d0;
        bus.eu1_wb_en   = en1;
        bus.eu1_wb_rd   = rd1;
        bus.eu1_wb_data = d1;
    endtask

    task automatic offer(input logic v, input logic [4:0] rd);
        bus.lu_valid = v;
        bus.lu_rd    = rd;
        bus.lu_data  = 32'h100 + 32'(rd);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        lanes(0, 0, 0, 0, 0, 0);
        offer(0, 0);
        repeat (3) tick();

        check("rst_en0", 64'(bus.write_en_0), 0);
        check("rst_en1", 64'(bus.write_en_1), 0);
        check("rst_addr0", 64'(bus.write_addr_0), 0);
        check("rst_data1", 64'(bus.write_data_1), 0);
        check("rst_count", 64'(bus.fifo_count), 0);
        check("rst_ready", 64'(bus.lu_ready), 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 64'(bus.lu_ready), 1);

        // Lane passthrough
        lanes(1, 3, 32'h11, 1, 4, 32'h22);
        tick();
        check("pass_en0", 64'(bus.write_en_0), 1);
        check("pass_addr0", 64'(bus.write_addr_0), 3);
        check("pass_data0", 64'(bus.write_data_0), 32'h11);
        check("pass_en1", 64'(bus.write_en_1), 1);
        check("pass_addr1", 64'(bus.write_addr_1), 4);
        check("pass_data1", 64'(bus.write_data_1), 32'h22);

        // WAW: lane 1 wins, port 0 holds its old addr/data
        lanes(1, 7, 32'hA, 1, 7, 32'hB);
        tick();
        check("waw_en0", 64'(bus.write_en_0), 0);
        check("waw_en1", 64'(bus.write_en_1), 1);
        check("waw_addr1", 64'(bus.write_addr_1), 7);
        check("waw_data1", 64'(bus.write_data_1), 32'hB);
        check("hold_addr0", 64'(bus.write_addr_0), 3);
        check("hold_data0", 64'(bus.write_data_0), 32'h11);

        // r0 write dropped
        lanes(1, 0, 32'h55, 0, 0, 0);
        tick();
        check("r0_en0", 64'(bus.write_en_0), 0);
        check("r0_en1", 64'(bus.write_en_1), 0);

        // Fill with both lanes busy
        lanes(1, 20, 32'h20, 1, 21, 32'h21);
        for (int i = 1; i <= 4; i++) begin
            offer(1, 5'(i));
            tick();
            check("fill_count", 64'(bus.fifo_count), 64'(i));
        end
        offer(1, 5);
        tick();
        check("full_ready", 64'(bus.lu_ready), 0);
        check("full_count", 64'(bus.fifo_count), 4);

        // Lanes idle: r1,r2 then r3,r4 (r5 pushed meanwhile) then r5
        lanes(0, 0, 0, 0, 0, 0);
        tick();
        check("drain1_en0", 64'(bus.write_en_0), 1);
        check("drain1_addr0", 64'(bus.write_addr_0), 1);
        check("drain1_data0", 64'(bus.write_data_0), 32'h101);
        check("drain1_en1", 64'(bus.write_en_1), 1);
        check("drain1_addr1", 64'(bus.write_addr_1), 2);
        check("drain1_count", 64'(bus.fifo_count), 2);
        tick();
        check("drain2_addr0", 64'(bus.write_addr_0), 3);
        check("drain2_addr1", 64'(bus.write_addr_1), 4);
        check("drain2_data1", 64'(bus.write_data_1), 32'h104);
        check("drain2_count", 64'(bus.fifo_count), 1);
        offer(0, 0);
        tick();
        check("drain3_en0", 64'(bus.write_en_0), 1);
        check("drain3_addr0", 64'(bus.write_addr_0), 5);
        check("drain3_data0", 64'(bus.write_data_0), 32'h105);
        check("drain3_en1", 64'(bus.write_en_1), 0);
        check("drain3_count", 64'(bus.fifo_count), 0);

        // Partial drain: only lane 0 writes, port 1 takes the head
        lanes(1, 20, 32'h20, 1, 21, 32'h21);
        offer(1, 9);
        tick();
        offer(1, 10);
        tick();
        offer(0, 0);
        lanes(1, 22, 32'h22, 0, 0, 0);
        tick();
        check("part1_en0", 64'(bus.write_en_0), 1);
        check("part1_addr0", 64'(bus.write_addr_0), 22);
        check("part1_en1", 64'(bus.write_en_1), 1);
        check("part1_addr1", 64'(bus.write_addr_1), 9);
        check("part1_count", 64'(bus.fifo_count), 1);
        tick();
        check("part2_addr1", 64'(bus.write_addr_1), 10);
        check("part2_data1", 64'(bus.write_data_1), 32'h10A);
        check("part2_count", 64'(bus.fifo_count), 0);

        // rd==0 entry consumes a slot without writing
        lanes(1, 20, 32'h20, 1, 21, 32'h21);
        offer(1, 0);
        tick();
        offer(1, 11);
        tick();
        offer(0, 0);
        lanes(0, 0, 0, 0, 0, 0);
        tick();
        check("zero_en0", 64'(bus.write_en_0), 0);
        check("zero_en1", 64'(bus.write_en_1), 1);
        check("zero_addr1", 64'(bus.write_addr_1), 11);
        check("zero_count", 64'(bus.fifo_count), 0);

        // Push refused at full even with a same-cycle pop
        lanes(1, 20, 32'h20, 1, 21, 32'h21);
        for (int i = 12; i <= 15; i++) begin
            offer(1, 5'(i));
            tick();
        end
        check("pp_full", 64'(bus.fifo_count), 4);
        offer(1, 16);
        lanes(1, 22, 32'h22, 0, 0, 0);
        tick();
        check("pp_count3", 64'(bus.fifo_count), 3);
        check("pp_addr1", 64'(bus.write_addr_1), 12);
        check("pp_ready", 64'(bus.lu_ready), 1);
        lanes(1, 20, 32'h20, 1, 21, 32'h21);
        tick();
        check("pp_count4", 64'(bus.fifo_count), 4);
        offer(0, 0);

        // Drain to empty, then refill to 3 for the reset test
        lanes(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("empty_again", 64'(bus.fifo_count), 0);
        lanes(1, 20, 32'h20, 1, 21, 32'h21);
        for (int i = 17; i <= 19; i++) begin
            offer(1, 5'(i));
            tick();
        end
        offer(0, 0);
        check("pre_rst_count", 64'(bus.fifo_count), 3);
        check("pre_rst_en0", 64'(bus.write_en_0), 1);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        check("arst_en0", 64'(bus.write_en_0), 0);
        check("arst_en1", 64'(bus.write_en_1), 0);
        check("arst_count", 64'(bus.fifo_count), 0);
        check("arst_ready", 64'(bus.lu_ready), 0);
        lanes(0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_en0", 64'(bus.write_en_0), 0);
            check("post_rst_en1", 64'(bus.write_en_1), 0);
            check("post_rst_count", 64'(bus.fifo_count), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
